// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types, instruction field positions and reset PC
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } ifu_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;

  // Branch displacement in bytes: sign-extended word offset shifted left by 2.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc.sv
// rtl/next_pc.sv - combinational next-PC select: jump, taken branch or fall-through
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  input  logic        j,
  input  logic        b,
  input  logic        zero,
  output logic [31:0] npc
);

  // Jump has priority over branch; sums wrap modulo 2^32.
  always_comb begin
    npc = pc4;
    if (j) begin
      npc = {pc4[31:28], instr_index, 2'b00};
    end else if (b && zero) begin
      npc = pc4 + branch_offset(imm16);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage (PC, IR, BOOT/FETCH/EXEC FSM); optional IFU_PERF_CNT_EN retire counter
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        J,
  input  logic        B,
  input  logic        Zero,
  output logic [31:0] Instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] Imm16,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        instr_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc;

  assign PC        = pc_q;
  assign PC4       = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign Instr     = instr_q;
  assign OpCode    = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign Rs        = instr_q[RS_MSB:RS_LSB];
  assign Rt        = instr_q[RT_MSB:RT_LSB];
  assign Rd        = instr_q[RD_MSB:RD_LSB];
  assign Funct     = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign Imm16     = instr_q[IMM_MSB:IMM_LSB];

  next_pc u_next_pc (
    .pc4         (PC4),
    .instr_index (instr_q[JIDX_MSB:JIDX_LSB]),
    .imm16       (instr_q[IMM_MSB:IMM_LSB]),
    .j           (J),
    .b           (B),
    .zero        (Zero),
    .npc         (npc)
  );

  // Next-state, PC/IR load and memory-request decode; ack outside FETCH is ignored.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_d    = npc;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, PC and IR registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  assign retire_cnt = retire_cnt_q;

  // An instruction retires on every EXEC cycle that is not stalled.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (state_q == ST_EXEC && !stall) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // Retired-instruction counter register, wraps at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= 32'h0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end
`endif

endmodule
